sample_history_reader: RTL

Circular history buffer for complex samples that replays the most recent DEPTH samples, newest first, as a valid/ready stream on request. It sits on the consumer side of the sample-delay path and feeds the FIR/LMS multiply-accumulate stages, which need x(n), x(n-1), …, x(n-DEPTH+1) once per new sample. Writes and replay are mutually exclusive, so every replay is a consistent snapshot.

---
 rtl/anc_pkg.sv | 17 +
 rtl/history_ram.sv | 52 +++++
 rtl/sample_history_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/anc_pkg.sv
// Shared types for the adaptive-canceller sample path: sample width,
// complex sample struct and the history reader FSM state encoding.
package anc_pkg;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } hist_state_t;

endpackage

// File: rtl/history_ram.sv
// DEPTH x complex-sample storage, one write port, one registered read port.
// HISTORY_ZERO_FILL_EN: reset clears every entry (otherwise RAM-inferable).
module history_ram
  import anc_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  cplx_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rzero_i,
  output cplx_t         rdata_o
);

  cplx_t mem_q [DEPTH];
  cplx_t rdata_q;

`ifdef HISTORY_ZERO_FILL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`endif

  // Read register holds when re_i is low so stalled outputs stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_history_reader.sv
// Circular sample history, replayed newest-first as a valid/ready stream.
// HISTORY_ZERO_FILL_EN: zero the array on reset and mask slots at/after fill_count.
//   state  | meaning
//   IDLE   | accepting writes, waiting for rd_start
//   STREAM | replaying DEPTH samples, writes blocked
module sample_history_reader
  import anc_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int FW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_re_i,
  input  logic [WIDTH-1:0] wr_im_i,
  input  logic             rd_start_i,
  output logic             rd_busy_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_re_o,
  output logic [WIDTH-1:0] rd_im_o,
  output logic [AW-1:0]    rd_idx_o,
  output logic             rd_last_o,
  output logic [FW-1:0]    fill_count_o
);

  hist_state_t   state_q, state_d;
  logic [AW-1:0] wp_q, base_q, fetch_q, rd_idx_q;
  logic [FW-1:0] fill_q;
  logic          rd_valid_q, rd_last_q;
  logic          wr_fire, fetch_en, hs_last, rzero;
  cplx_t         wdata, rdata;

  assign wr_fire = wr_valid_i & wr_ready_o;
  assign hs_last = rd_valid_q & rd_ready_i & rd_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_start_i) state_d = STREAM;
      STREAM:  if (hs_last)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // fetch_q runs one ahead of rd_idx_q so a full replay needs no bubbles.
  always_comb begin
    wr_ready_o = 1'b0;
    rd_busy_o  = 1'b0;
    fetch_en   = 1'b0;
    case (state_q)
      IDLE: wr_ready_o = 1'b1;
      STREAM: begin
        rd_busy_o = 1'b1;
        fetch_en  = !rd_valid_q || (rd_ready_i && !rd_last_q);
      end
      default: wr_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q   <= '0;
      fill_q <= '0;
    end else if (wr_fire) begin
      wp_q <= wp_q + AW'(1);
      if (fill_q != FW'(DEPTH)) begin
        fill_q <= fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      fetch_q    <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      // A same-cycle write lands at wp, making it the newest sample.
      if (state_q == IDLE && rd_start_i) begin
        base_q  <= wr_fire ? wp_q : wp_q - AW'(1);
        fetch_q <= '0;
      end
      if (fetch_en) begin
        fetch_q    <= fetch_q + AW'(1);
        rd_idx_q   <= fetch_q;
        rd_last_q  <= (fetch_q == AW'(DEPTH - 1));
        rd_valid_q <= 1'b1;
      end else if (hs_last) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

`ifdef HISTORY_ZERO_FILL_EN
  assign rzero = ({1'b0, fetch_q} >= fill_q);
`else
  assign rzero = 1'b0;
`endif

  assign wdata = '{re: wr_re_i, im: wr_im_i};

  history_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_fire & !reset),
    .waddr_i (wp_q),
    .wdata_i (wdata),
    .re_i    (fetch_en),
    .raddr_i (base_q - fetch_q),
    .rzero_i (rzero),
    .rdata_o (rdata)
  );

  assign rd_valid_o   = rd_valid_q;
  assign rd_re_o      = rdata.re;
  assign rd_im_o      = rdata.im;
  assign rd_idx_o     = rd_idx_q;
  assign rd_last_o    = rd_last_q;
  assign fill_count_o = fill_q;

endmodule
